// File: rtl/regfile_writeback_pkg.sv
// Shared types and defaults for the register-file writeback block.
//   WB_DATA_W / WB_ADDR_W : default register data / address widths
//   REG_ZERO              : address of the hardwired-zero register
//   wb_req_t              : one writeback request {valid, rd, data}
package regfile_writeback_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// LSU result handshake into the writeback block.
//   lsu_valid  : LSU result offered        (master -> slave)
//   lsu_rd     : result destination        (master -> slave)
//   lsu_data   : result data               (master -> slave)
//   lsu_ready  : writeback buffer accepts  (slave -> master)
interface regfile_writeback_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;

  modport master (output lsu_valid, output lsu_rd, output lsu_data, input  lsu_ready);
  modport slave  (input  lsu_valid, input  lsu_rd, input  lsu_data, output lsu_ready);
endinterface

// File: rtl/regfile_writeback_wb_result_fifo.sv
// In-order result FIFO for buffered LSU writebacks.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : enqueue; ignored while full, even if a pop happens that cycle
//   pop        : dequeue head; ignored while empty
//   head       : current head entry (valid only when !empty)
//   count      : number of stored entries (0..DEPTH)
//   empty      : count == 0
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write side: merges single-cycle ALU results and buffered LSU
// results onto the one write port, and tracks destinations of outstanding
// loads so issue can stall dependent readers.
//   clk, rst_n            : clock, async active-low reset
//   alu_valid/rd/data     : ALU result; alu_stall asks the ALU to hold it
//   issue_valid/issue_rd  : load issued; marks issue_rd pending
//   lsu (slave modport)   : LSU result handshake into the result buffer
//   rs1/rs2_addr -> busy  : pending-load probe for issue
//   wb_write/addr/data    : registered register-file write port
// Optional: REGFILE_WB_STARVE_GUARD_EN lets a buffered LSU result force its
// way past a continuously busy ALU after STARVE_MAX lost cycles.
// The request struct is sized by the package widths, which DATA_W/ADDR_W
// default to.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  regfile_writeback_if.slave lsu,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wb_write,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int W    = ADDR_W + DATA_W;

  if (DEPTH < 1 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("regfile_writeback: DEPTH and STARVE_MAX must be >= 1");
  end

  // ---- LSU result buffer ----
  logic [W-1:0]      head;
  logic [CW-1:0]     count;
  logic              empty, pop;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  assign lsu.lsu_ready = (count < CW'(DEPTH));
  assign head_rd       = head[W-1 -: ADDR_W];
  assign head_data     = head[DATA_W-1:0];

  wb_result_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lsu.lsu_valid & lsu.lsu_ready),
    .din   ({lsu.lsu_rd, lsu.lsu_data}),
    .pop   (pop),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  // ---- arbitration ----
  logic    alu_req, alu_take, starve;
  wb_req_t wb_nxt, wb_q;

  assign alu_req  = alu_valid & (alu_rd != REG_ZERO);
  assign pop      = ~empty & (~alu_req | starve);
  assign alu_take = alu_req & ~pop;

`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  assign starve    = ~empty & (starve_cnt == SW'(STARVE_MAX));
  assign alu_stall = alu_req & starve;

  // Counts cycles the waiting head lost to the ALU; any pop restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       starve_cnt <= '0;
    else if (pop)                                     starve_cnt <= '0;
    else if (~empty & (starve_cnt != SW'(STARVE_MAX))) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve    = 1'b0;
  assign alu_stall = 1'b0;
`endif

  always_comb begin
    wb_nxt = '0;
    if (alu_take)  wb_nxt = '{valid: 1'b1, rd: alu_rd, data: alu_data};
    else if (pop)  wb_nxt = '{valid: (head_rd != REG_ZERO), rd: head_rd, data: head_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_q <= '0;
    else        wb_q <= wb_nxt;
  end

  assign wb_write = wb_q.valid;
  assign wb_addr  = wb_q.rd;
  assign wb_data  = wb_q.data;

  // ---- pending-load scoreboard ----
  // The clear is applied one edge after the pop so the bit stays set through
  // the cycle the write is on wb_*; the register file write-through covers
  // readers in that cycle.
  logic [NREG-1:0]   sb, sb_nxt;
  logic              clr_vld;
  logic [ADDR_W-1:0] clr_rd;

  always_comb begin
    sb_nxt = sb;
    if (clr_vld) sb_nxt[clr_rd] = 1'b0;
    if (issue_valid && issue_rd != REG_ZERO) sb_nxt[issue_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb      <= '0;
      clr_vld <= 1'b0;
      clr_rd  <= '0;
    end else begin
      sb      <= sb_nxt;
      clr_vld <= pop;
      clr_rd  <= head_rd;
    end
  end

  assign rs1_busy = sb[rs1_addr] & (rs1_addr != REG_ZERO);
  assign rs2_busy = sb[rs2_addr] & (rs2_addr != REG_ZERO);
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int DW = 32, AW = 5, DEPTH = 2, SMAX = 4, NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          alu_valid, alu_stall, issue_valid;
  logic [AW-1:0] alu_rd, issue_rd, rs1_addr, rs2_addr, wb_addr;
  logic [DW-1:0] alu_data, wb_data;
  logic          rs1_busy, rs2_busy, wb_write;

  regfile_writeback_if #(.ADDR_W(AW), .DATA_W(DW)) lsu_if ();

  regfile_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .lsu(lsu_if.slave),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: queue of buffered results + set of pending rds ----
  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
  ent_t          q[$];
  bit            pend[NR];
  int            scnt, rel;
  bit            m_wr, last_stall;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic bit starve_now();
`ifdef REGFILE_WB_STARVE_GUARD_EN
    return (q.size() > 0) && (scnt >= SMAX);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_stall();
    return alu_valid && (alu_rd != 0) && starve_now();
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    scnt = 0; rel = -1; m_wr = 0; m_addr = '0; m_data = '0; last_stall = 0;
  endtask

  task automatic check_outputs();
    chk("wb_write", wb_write, m_wr);
    if (m_wr) begin
      chk("wb_addr", wb_addr, m_addr);
      chk("wb_data", wb_data, m_data);
    end
    chk("lsu_ready", lsu_if.lsu_ready, q.size() < DEPTH);
    chk("alu_stall", alu_stall, exp_stall());
    chk("rs1_busy", rs1_busy, pend[rs1_addr] && rs1_addr != 0);
    chk("rs2_busy", rs2_busy, pend[rs2_addr] && rs2_addr != 0);
  endtask

  // One clock edge of the specified behaviour, seen from the outside.
  task automatic model_edge();
    bit areq, pop, rdy;
    ent_t h;
    areq = alu_valid && alu_rd != 0;
    rdy  = q.size() < DEPTH;
    pop  = (q.size() > 0) && (!areq || starve_now());
    last_stall = exp_stall();
    if (rel >= 0) pend[rel] = 1'b0;   // released after its wb cycle
    rel = -1;
    if (pop) begin
      h = q.pop_front();
      m_wr = (h.rd != 0); m_addr = h.rd; m_data = h.data; rel = h.rd; scnt = 0;
    end else if (areq) begin
      m_wr = 1; m_addr = alu_rd; m_data = alu_data;
      if (q.size() > 0 && scnt < SMAX) scnt++;
    end else m_wr = 0;
    if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
    if (lsu_if.lsu_valid && rdy) q.push_back('{lsu_if.lsu_rd, lsu_if.lsu_data});
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    issue_valid = 0; issue_rd = '0;
    lsu_if.lsu_valid = 0; lsu_if.lsu_rd = '0; lsu_if.lsu_data = '0;
  endtask

  logic [AW-1:0] oq[$];
  bit            offering, acc;
  int            naccept;

  initial begin
    rst_n = 0; idle(); rs1_addr = '0; rs2_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_wb_write", wb_write, 1'b0);
    chk("rst_wb_addr", wb_addr, '0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_lsu_ready", lsu_if.lsu_ready, 1'b1);
    chk("rst_alu_stall", alu_stall, 1'b0);
    for (int a = 0; a < NR; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(NR - 1 - a);
      step();
    end

    // load to x5: busy from cycle 1, written in cycle 5, free in cycle 6
    rs1_addr = 5; rs2_addr = 0;
    issue_valid = 1; issue_rd = 5; step();
    issue_valid = 0;
    chk("ld5_busy_c1", rs1_busy, 1'b1);
    step(); step();
    lsu_if.lsu_valid = 1; lsu_if.lsu_rd = 5; lsu_if.lsu_data = 32'hDEADBEEF; step();
    lsu_if.lsu_valid = 0; step();
    chk("ld5_wr_c5", wb_write, 1'b1);
    chk("ld5_addr_c5", wb_addr, 5);
    chk("ld5_data_c5", wb_data, 32'hDEADBEEF);
    chk("ld5_busy_c5", rs1_busy, 1'b1);
    step();
    chk("ld5_busy_c6", rs1_busy, 1'b0);

    // ALU and LSU in the same cycle: ALU first, then LSU
    issue_valid = 1; issue_rd = 7; step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    lsu_if.lsu_valid = 1; lsu_if.lsu_rd = 7; lsu_if.lsu_data = 32'h22; step();
    idle();
    chk("same_alu_addr", wb_addr, 3);
    chk("same_alu_data", wb_data, 32'h11);
    step();
    chk("same_lsu_wr", wb_write, 1'b1);
    chk("same_lsu_addr", wb_addr, 7);
    chk("same_lsu_data", wb_data, 32'h22);
    step();

    // ALU busy every cycle while three LSU results arrive
    for (int i = 0; i < 3; i++) begin issue_valid = 1; issue_rd = AW'(16 + i); step(); end
    idle();
    oq = '{5'd16, 5'd17, 5'd18};
    naccept = 0;
    for (int c = 0; c < 10; c++) begin
      if (!last_stall) begin alu_valid = 1; alu_rd = 1; alu_data = $urandom; end
      if (oq.size() > 0) begin
        lsu_if.lsu_valid = 1; lsu_if.lsu_rd = oq[0]; lsu_if.lsu_data = 32'hA000 + oq[0];
      end else lsu_if.lsu_valid = 0;
      acc = lsu_if.lsu_valid && lsu_if.lsu_ready;
      step();
      if (acc) begin void'(oq.pop_front()); naccept++; end
    end
`ifndef REGFILE_WB_STARVE_GUARD_EN
    chk("busy_alu_accepts", naccept, 2);
    chk("busy_alu_ready_low", lsu_if.lsu_ready, 1'b0);
`endif
    alu_valid = 0;
    for (int c = 0; c < 8; c++) begin
      if (oq.size() > 0) begin
        lsu_if.lsu_valid = 1; lsu_if.lsu_rd = oq[0]; lsu_if.lsu_data = 32'hA000 + oq[0];
      end else lsu_if.lsu_valid = 0;
      acc = lsu_if.lsu_valid && lsu_if.lsu_ready;
      step();
      if (acc) void'(oq.pop_front());
    end
    chk("busy_alu_drained", oq.size(), 0);
    idle();

    // rd=0 from both producers never writes
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    lsu_if.lsu_valid = 1; lsu_if.lsu_rd = 0; lsu_if.lsu_data = 32'h55;
    rs1_addr = 0; step(); step();
    idle();
    step(); step(); step();
    chk("rd0_ready", lsu_if.lsu_ready, 1'b1);
    chk("rd0_busy", rs1_busy, 1'b0);

    // reset with two buffered entries and x5/x9 pending
    issue_valid = 1; issue_rd = 5;  step();
    issue_rd = 9;  step();
    issue_rd = 20; step();
    issue_rd = 21; step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 2; alu_data = 32'h77;
    lsu_if.lsu_valid = 1; lsu_if.lsu_rd = 20; lsu_if.lsu_data = 32'h20; step();
    lsu_if.lsu_rd = 21; lsu_if.lsu_data = 32'h21; step();
    lsu_if.lsu_valid = 0;
    chk("prerst_wr", wb_write, 1'b1);
    chk("prerst_ready", lsu_if.lsu_ready, 1'b0);
    #2 rst_n = 0;
    #1;
    chk("midrst_wr", wb_write, 1'b0);
    chk("midrst_ready", lsu_if.lsu_ready, 1'b1);
    model_reset();
    idle();
    @(posedge clk); #1 rst_n = 1;
    rs1_addr = 5; rs2_addr = 9;
    #1;
    chk("postrst_busy5", rs1_busy, 1'b0);
    chk("postrst_busy9", rs2_busy, 1'b0);
    step();

    // randomized traffic; ALU owns x1..x15, loads own x16..x31
    oq.delete(); offering = 0;
    for (int c = 0; c < 600; c++) begin
      if (!last_stall) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 15));
        alu_data  = $urandom;
      end
      issue_valid = 0;
      if ($urandom_range(0, 2) == 0) begin
        issue_rd = AW'($urandom_range(16, 31));
        issue_valid = !pend[issue_rd];
      end
      if (!offering) begin
        if (oq.size() > 0 && $urandom_range(0, 1) == 1) begin
          offering = 1; lsu_if.lsu_rd = oq[0]; lsu_if.lsu_data = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          offering = 1; lsu_if.lsu_rd = '0; lsu_if.lsu_data = $urandom;
        end
      end
      lsu_if.lsu_valid = offering;
      rs1_addr = AW'($urandom); rs2_addr = AW'($urandom);
      acc = lsu_if.lsu_valid && lsu_if.lsu_ready;
      step();
      if (acc) begin
        if (lsu_if.lsu_rd != 0) void'(oq.pop_front());
        offering = 0; lsu_if.lsu_valid = 0;
      end
      if (issue_valid) oq.push_back(issue_rd);
    end
    idle();
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
